// File: rtl/sponge_padder.sv
// Keccak sponge input stage: packs message words into rate-sized blocks
// and applies the FIPS-202 domain suffix plus pad10*1 padding.
module sponge_padder #(
  parameter int IN_W     = 64,
  parameter int MAX_RATE = 1344,
  parameter int BN_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          mode,
  input  logic [IN_W-1:0]     in,
  input  logic                in_ready,
  input  logic                is_last,
  input  logic [BN_W-1:0]     byte_num,
  output logic                buffer_full,
  output logic [MAX_RATE-1:0] out,
  output logic                out_ready,
  output logic                out_last,
  input  logic                f_ack
);

  localparam int NB = IN_W / 8;
  localparam int MW = MAX_RATE / IN_W;
  localparam int IW = $clog2(MW) + 1;

  typedef enum logic [1:0] {
    ABSORB,
    FULL,
    PAD_ONLY
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [2:0]    mode_q;
  logic          in_msg;
  logic          pad_pend;

  function automatic logic [2:0] norm(input logic [2:0] m);
    return (m > 3'd5) ? 3'd3 : m;
  endfunction

  function automatic logic [10:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    return 11'd1152;
      3'd1:    return 11'd1088;
      3'd2:    return 11'd832;
      3'd4:    return 11'd1344;
      3'd5:    return 11'd1088;
      default: return 11'd576;
    endcase
  endfunction

  function automatic logic [7:0] sfx_of(input logic [2:0] m);
    return m[2] ? 8'h1F : 8'h06;
  endfunction

  logic [2:0]          cur_mode;
  logic [10:0]         rate;
  logic [10:0]         q_rate;
  logic [7:0]          sfx;
  logic [IW-1:0]       rw;
  logic                last_slot;
  logic                partial;
  logic                accept;
  logic                fin_here;
  logic                pad_next;
  logic [IN_W-1:0]     mask;
  logic [IN_W-1:0]     word_v;
  logic [MAX_RATE-1:0] put;
  logic [MAX_RATE-1:0] sfx_nx;
  logic [MAX_RATE-1:0] end_v;
  logic [MAX_RATE-1:0] buf_n;
  logic [MAX_RATE-1:0] pad_blk;

  assign cur_mode  = in_msg ? mode_q : norm(mode);
  assign rate      = rate_of(cur_mode);
  assign q_rate    = rate_of(mode_q);
  assign sfx       = sfx_of(cur_mode);
  assign rw        = IW'(32'(rate) / IN_W);
  assign last_slot = (idx == rw - IW'(1));
  assign partial   = (byte_num < BN_W'(NB));
  assign accept    = in_ready && !buffer_full;
  assign fin_here  = is_last && (partial || !last_slot);
  assign pad_next  = is_last && !partial && last_slot;

  // The buffer is zero beyond the write slot, so OR-ing places each field.
  always_comb begin
    mask   = ~({IN_W{1'b1}} >> (8 * int'(byte_num)));
    word_v = in;
    if (is_last && partial)
      word_v = (in & mask)
             | ((IN_W'(sfx) << (IN_W - 8)) >> (8 * int'(byte_num)));
    put    = (MAX_RATE'(word_v) << (MAX_RATE - IN_W))
             >> (int'(idx) * IN_W);
    sfx_nx = (MAX_RATE'(sfx) << (MAX_RATE - 8))
             >> ((int'(idx) + 1) * IN_W);
    end_v  = MAX_RATE'(8'h80) << (MAX_RATE - 32'(rate));
    buf_n  = out | put;
    if (is_last && !partial && !last_slot)
      buf_n = buf_n | sfx_nx;
    if (fin_here)
      buf_n = buf_n | end_v;
    pad_blk = (MAX_RATE'(sfx_of(mode_q)) << (MAX_RATE - 8))
            | (MAX_RATE'(8'h80) << (MAX_RATE - 32'(q_rate)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ABSORB;
      idx         <= '0;
      mode_q      <= 3'd3;
      in_msg      <= 1'b0;
      pad_pend    <= 1'b0;
      out         <= '0;
      out_ready   <= 1'b0;
      out_last    <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      case (state)
        ABSORB: begin
          if (accept) begin
            out    <= buf_n;
            mode_q <= cur_mode;
            in_msg <= !is_last;
            if (last_slot || is_last) begin
              state       <= FULL;
              idx         <= '0;
              out_ready   <= 1'b1;
              out_last    <= fin_here;
              buffer_full <= 1'b1;
              pad_pend    <= pad_next;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FULL: begin
          if (f_ack) begin
            out       <= '0;
            out_ready <= 1'b0;
            out_last  <= 1'b0;
            idx       <= '0;
            if (pad_pend) begin
              state <= PAD_ONLY;
            end else begin
              state       <= ABSORB;
              buffer_full <= 1'b0;
            end
          end
        end
        PAD_ONLY: begin
          out       <= pad_blk;
          out_ready <= 1'b1;
          out_last  <= 1'b1;
          pad_pend  <= 1'b0;
          state     <= FULL;
        end
        default: state <= ABSORB;
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_padder.sv
// Scoreboard bench for sponge_padder: directed messages, byte-level
// expected blocks queued at issue time, monitor compares on out_ready.
module tb_sponge_padder;
  localparam int MR = 1344;

  typedef struct {
    logic [MR-1:0] blk;
    logic          last;
    int            id;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    mode = 3'd3;
  logic [63:0]   din = '0;
  logic          in_ready = 1'b0;
  logic          is_last = 1'b0;
  logic [3:0]    byte_num = '0;
  logic          buffer_full;
  logic [MR-1:0] dout;
  logic          out_ready;
  logic          out_last;
  logic          f_ack = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   ack_delay = 0;
  int   blk_id = 0;
  exp_t q[$];
  logic [7:0] msg [0:255];

  sponge_padder #(.IN_W(64), .MAX_RATE(MR), .BN_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in(din),
    .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
    .buffer_full(buffer_full), .out(dout), .out_ready(out_ready),
    .out_last(out_last), .f_ack(f_ack)
  );

  always #5 clk = ~clk;

  function automatic int rate_bytes(input logic [2:0] m);
    case (m)
      3'd0:    return 144;
      3'd1:    return 136;
      3'd2:    return 104;
      3'd4:    return 168;
      3'd5:    return 136;
      default: return 72;
    endcase
  endfunction

  function automatic logic [7:0] sfx_byte(input logic [2:0] m);
    return (m == 3'd4 || m == 3'd5) ? 8'h1F : 8'h06;
  endfunction

  task automatic check1(input string nm, input logic [31:0] got,
                        input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic check_blk(input int id, input logic [MR-1:0] got,
                           input logic [MR-1:0] want);
    int bad;
    bad = -1;
    checks++;
    for (int k = MR / 8 - 1; k >= 0; k--)
      if (got[MR-1-8*k -: 8] !== want[MR-1-8*k -: 8]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL block%0d byte %0d: got %h want %h", id, bad,
               got[MR-1-8*bad -: 8], want[MR-1-8*bad -: 8]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   wc;
    bit   seen;
    wc = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      f_ack = 1'b0;
      if (out_ready === 1'b1) begin
        if (!seen) begin
          seen = 1;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_block: got one want none");
          end else begin
            e = q.pop_front();
            check_blk(e.id, dout, e.blk);
            check1($sformatf("last%0d", e.id), 32'(out_last),
                   32'(e.last));
          end
        end
        if (wc >= ack_delay) begin
          f_ack = 1'b1;
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        seen = 0;
        wc = 0;
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic l,
                           input logic [3:0] bn, input logic [2:0] md,
                           output int waited);
    @(negedge clk);
    din = d;
    is_last = l;
    byte_num = bn;
    mode = md;
    in_ready = 1'b1;
    waited = 0;
    while (buffer_full && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got stuck want accept");
    end
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    is_last = 1'b0;
  endtask

  task automatic send_msg(input int len, input logic [2:0] md,
                          input logic [2:0] alt, output int wmax);
    int         r;
    int         nblk;
    int         nw;
    int         pos;
    int         wt;
    logic [7:0] s;
    logic [7:0] bv;
    logic [63:0] d;
    logic [3:0] bn;
    exp_t       e;
    r = rate_bytes(md);
    s = sfx_byte(md);
    nblk = len / r + 1;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < r; k++) begin
        pos = b * r + k;
        bv = (pos < len) ? msg[pos] : 8'h00;
        if (pos == len) bv = bv | s;
        if (b == nblk - 1 && k == r - 1) bv = bv | 8'h80;
        e.blk[MR-1-8*k -: 8] = bv;
      end
      e.last = (b == nblk - 1);
      e.id = blk_id++;
      q.push_back(e);
    end
    nw = (len == 0) ? 1 : (len + 7) / 8;
    wmax = 0;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++)
        d[63-8*j -: 8] = (8 * w + j < len) ? msg[8*w+j] : 8'hEE;
      bn = (len - 8 * w >= 8) ? 4'd8 : 4'(len - 8 * w);
      send_word(d, w == nw - 1, bn, (w == 0) ? md : alt, wt);
      if (wt > wmax) wmax = wt;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || out_ready || buffer_full) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_drain: got pending %0d want 0", nm, q.size());
    end
  endtask

  initial begin : stim
    int wm;
    int wt;
    for (int k = 0; k < 256; k++) msg[k] = 8'(k);

    #2;
    check1("rst_out_ready", 32'(out_ready), 0);
    check1("rst_out_last", 32'(out_last), 0);
    check1("rst_buffer_full", 32'(buffer_full), 0);
    check1("rst_out_zero", 32'(dout != '0), 0);
    @(negedge clk);
    reset = 1'b1;

    send_msg(64, 3'd3, 3'd3, wm);
    check1("sha3_512_latency", 32'(out_ready), 1);
    drain("sha3_512_64");

    send_msg(0, 3'd4, 3'd4, wm);
    drain("shake128_empty");

    send_msg(72, 3'd3, 3'd3, wm);
    drain("sha3_512_72");
    check1("pad_only_exit_bf", 32'(buffer_full), 0);

    send_msg(135, 3'd1, 3'd1, wm);
    drain("sha3_256_135");
    send_msg(135, 3'd5, 3'd5, wm);
    drain("shake256_135");

    ack_delay = 10;
    send_msg(80, 3'd3, 3'd4, wm);
    check1("backpressure_hold", 32'(wm >= 10), 1);
    drain("backpressure");
    ack_delay = 0;

    for (int w = 0; w < 5; w++)
      send_word({8{8'(w + 8'h41)}}, 1'b0, 4'd8, 3'd2, wt);
    @(negedge clk);
    check1("pre_rst_nonzero", 32'(dout != '0), 1);
    #2;
    reset = 1'b0;
    #1;
    check1("midrst_out_zero", 32'(dout != '0), 0);
    check1("midrst_out_ready", 32'(out_ready), 0);
    check1("midrst_buffer_full", 32'(buffer_full), 0);
    @(negedge clk);
    reset = 1'b1;
    send_msg(8, 3'd2, 3'd2, wm);
    drain("post_reset_sha3_384");

    check1("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sponge_padder.md
Name: sponge_padder

Overview:
- Parametrised multi-mode Keccak sponge input stage.
- Accepts message words of IN_W bits and assembles rate-sized blocks.
- Applies FIPS-202 domain suffix and pad10*1 padding for SHA3-224/256/384/512 and SHAKE128/256; the mode is selected per message.
- Hands each block to the f_permutation absorb stage through a ready/ack handshake. Used by the Kyber hash/XOF front end.

Parameters:
- IN_W, 64, input word width in bits; legal values are 8, 16, 32, 64.
- MAX_RATE, 1344, output block width in bits (SHAKE128 rate).
- BN_W, 4, width of byte_num; must hold values 0..IN_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- mode  in  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256; 6 and 7 are reserved and treated as 3
- in  in  IN_W  message word; first byte in in[IN_W-1 -: 8]
- in_ready  in  1  word valid
- is_last  in  1  the current word is the final word of the message
- byte_num  in  BN_W  number of valid bytes in the final word (0..IN_W/8); ignored unless is_last=1
- buffer_full  out  1  no word is accepted this cycle
- out  out  MAX_RATE  assembled block, MSB-aligned in out[MAX_RATE-1 -: rate]; lower bits are 0
- out_ready  out  1  block valid
- out_last  out  1  the block on out is the final block of the message
- f_ack  in  1  permutation has consumed the block on out

Behaviour:
- Rate is fixed by mode: 1152, 1088, 832, 576, 1344, 1088 bits. rate_words = rate/IN_W.
- Domain suffix byte: 0x06 for SHA3 modes, 0x1F for SHAKE modes.
- mode is latched with the first accepted word of a message. Changes to mode mid-message are ignored.
- A word is accepted on a rising edge when in_ready=1 and buffer_full=0. in_ready while buffer_full=1 is ignored; the source must hold the word.
- States:
  - ABSORB: word counter i runs 0..rate_words-1. Each accepted word is written to slot i and i increments.
  - FULL: out_ready=1 and buffer_full=1. The state holds until f_ack=1.
  - PAD_ONLY: an extra padding block is pending; buffer_full=1.
- Non-last word fills the block (i = rate_words-1): go to FULL next cycle with out_last=0.
- Last word, partial (byte_num < IN_W/8):
  - bytes 0..byte_num-1 = data; byte byte_num = suffix; remaining bytes of the word and all remaining slots = 0;
  - last byte of the block |= 0x80;
  - go to FULL next cycle with out_last=1.
- Last word, full (byte_num = IN_W/8):
  - If i < rate_words-1: slot i+1 byte 0 = suffix, remaining slots = 0, last byte |= 0x80, go to FULL with out_last=1.
  - If the word fills the block: go to FULL with out_last=0, then PAD_ONLY.
- When suffix and 0x80 land on the same byte, the byte is their OR: 0x86 (SHA3) or 0x9F (SHAKE).
- Empty message (is_last=1, byte_num=0 with i=0): block byte 0 = suffix, last byte |= 0x80.
- Latency: out_ready rises exactly one cycle after the edge that accepts the completing word.
- f_ack in FULL:
  - next cycle out_ready=0, the block buffer is cleared, i=0;
  - if PAD_ONLY is pending, the next cycle presents the padding block (suffix at byte 0, 0x80 in the last byte, out_last=1, out_ready=1), and a further f_ack returns to ABSORB.
- f_ack while out_ready=0 is ignored.
- out is stable while out_ready=1.
- buffer_full=1 in FULL and PAD_ONLY, else 0. Words arriving in the same cycle as f_ack are not accepted.
- Reset (asynchronous, active-low), at any point including mid-message or mid-handshake:
  - out=0, out_ready=0, out_last=0, buffer_full=0, i=0, state=ABSORB;
  - the latched mode is 3;
  - any partial block is discarded.

Test Plan:
- SHA3-512, IN_W=64, 64-byte message 0x00..0x3F as 8 words, last word with is_last=1, byte_num=8:
  - out_ready rises 1 cycle after the 8th word, out_last=1;
  - bytes 0..63 = data, byte 64 = 0x06, bytes 65..70 = 0x00, byte 71 = 0x80, out[767:0]=0.
- SHAKE128, empty message (is_last=1, byte_num=0): block byte 0 = 0x1F, bytes 1..166 = 0, byte 167 = 0x80, out_last=1.
- SHA3-512, 72-byte message (9 full words):
  - block 1 = data with out_last=0;
  - after f_ack, block 2 = byte 0 0x06, bytes 1..70 = 0, byte 71 = 0x80, out_last=1;
  - a second f_ack returns to ABSORB with buffer_full=0.
- SHA3-256, 135-byte message (last word byte_num=7): byte 135 = 0x86. SHAKE256 with the same message: byte 135 = 0x9F.
- Backpressure: hold in_ready=1 with new words while FULL and withhold f_ack for 10 cycles; no word is accepted. After f_ack the held word lands in slot 0 of the next block. A mode change mid-message leaves the rate unchanged.
- Assert reset after 5 words of a SHA3-384 message: all outputs go to 0 immediately; a fresh 1-word message then pads correctly in mode 2 (byte 831/8 position).
